// File: rtl/en_reg_pipe_if.sv
// Handshake bundle for en_reg_pipe: upstream valid/ready/data and downstream valid/ready/data.
interface en_reg_pipe_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/en_reg_pipe.sv
// Enabled register pipeline of DEPTH stages with bubble collapsing, hold and flush.
// State updates on the falling edge of clk.
module en_reg_pipe #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DEPTH       = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                   CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  en_reg_pipe_if.slave     bus,
  output logic [CNT_W-1:0] count
);
  logic [DEPTH-1:0]                 vld;
  logic [DEPTH-1:0]                 adv;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data;
  logic blk, out_xfer, in_xfer;

  // rst also blocks the handshake so nothing looks transferable during reset
  assign blk          = rst | hold | flush;
  assign bus.out_valid = vld[DEPTH-1] & ~blk;
  assign bus.out_data  = data[DEPTH-1];
  assign out_xfer     = bus.out_valid & bus.out_ready;

  // A stage advances unless every stage downstream of it is full and the tail is stuck;
  // this is the unrolled form of adv[i] = vld[i] & (~vld[i+1] | adv[i+1]).
  always_comb begin
    logic full_above;
    adv        = '0;
    full_above = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]     = vld[i] & ~blk & (out_xfer | ~full_above);
      full_above = full_above & vld[i];
    end
  end

  assign bus.in_ready = ~blk & (~vld[0] | adv[0]);
  assign in_xfer      = bus.in_valid & bus.in_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic                  load;
    logic [DATA_WIDTH-1:0] src;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] data_q;

    if (i == 0) begin : g_head
      assign load = in_xfer;
      assign src  = bus.in_data;
    end else begin : g_body
      assign load = adv[i-1];
      assign src  = data[i-1];
    end

    // Data is only written on load, so advance and flush leave stale words in place.
    always_ff @(negedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= RESET_VALUE;
      end else if (flush) begin
        vld_q <= 1'b0;
      end else if (load) begin
        vld_q  <= 1'b1;
        data_q <= src;
      end else if (adv[i]) begin
        vld_q <= 1'b0;
      end
    end

    assign vld[i]  = vld_q;
    assign data[i] = data_q;
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CNT_W'(vld[i]);
  end
endmodule

// File: tb/tb_en_reg_pipe.sv
// Directed bench for en_reg_pipe with a queue-based reference model checked every cycle.
module tb_en_reg_pipe;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          hold = 1'b0;
  logic [CW-1:0] count;

  en_reg_pipe_if #(.DATA_WIDTH(DW)) bus ();

  en_reg_pipe #(.DATA_WIDTH(DW), .DEPTH(D), .RESET_VALUE(8'h00)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .hold  (hold),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] got[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(string nm);
    chk({nm, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({nm, "_word"}, got[i], exp_q[i]);
  endtask

  // Reference model: words in flight, oldest first, each with its stage index.
  // Words packed against the output stay put unless the oldest leaves; all others step forward.
  logic [DW-1:0] m_data[$];
  int            m_pos[$];
  bit            live = 1'b0;

  always begin
    bit eb, eov, eir, oxf, ixf;
    int n, L;
    @(posedge clk);
    #4;
    eb = rst | hold | flush;
    n  = m_data.size();
    L  = 0;
    while (L < n && m_pos[L] == D - 1 - L) L++;
    eov = !eb && n > 0 && m_pos[0] == D - 1;
    oxf = eov && bus.out_ready;
    eir = !eb && (n == 0 || m_pos[n-1] != 0 || oxf || L < n);
    ixf = eir && bus.in_valid;
    if (live) begin
      chk("m_out_valid", bus.out_valid, eov);
      chk("m_in_ready", bus.in_ready, eir);
      chk("m_count", count, n);
      if (eov) chk("m_out_data", bus.out_data, m_data[0]);
    end
    @(negedge clk);
    if (rst) begin
      m_data.delete();
      m_pos.delete();
      live = 1'b1;
    end else if (flush) begin
      m_data.delete();
      m_pos.delete();
    end else if (!hold) begin
      if (oxf) begin
        void'(m_data.pop_front());
        void'(m_pos.pop_front());
      end
      for (int j = 0; j < m_pos.size(); j++)
        if (oxf || j >= L) m_pos[j]++;
      if (ixf) begin
        m_data.push_back(bus.in_data);
        m_pos.push_back(0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(bit v, logic [DW-1:0] d, bit ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  task automatic drain(int n);
    got.delete();
    setin(1'b0, 8'h00, 1'b1);
    repeat (n) begin
      #3;
      if (bus.out_valid) got.push_back(bus.out_data);
      tick();
    end
  endtask

  initial begin
    int first_acc, first_ov;
    bit rdy_low;
    setin(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_out_data", bus.out_data, 8'h00);
    tick();
    rst = 1'b0;

    // Streaming 0x01..0x08
    first_acc = -1;
    first_ov  = -1;
    rdy_low   = 1'b0;
    got.delete();
    for (int c = 0; c < 14; c++) begin
      if (c < 8) setin(1'b1, 8'(c + 1), 1'b1);
      else       setin(1'b0, 8'h00, 1'b1);
      #3;
      if (c < 8 && !bus.in_ready) rdy_low = 1'b1;
      if (first_acc < 0 && bus.in_valid && bus.in_ready) first_acc = c;
      if (first_ov < 0 && bus.out_valid) first_ov = c;
      if (c >= 3 && c <= 8) chk("stream_count_range", (count >= 3 && count <= 4), 1);
      if (bus.out_valid) got.push_back(bus.out_data);
      tick();
    end
    // accept at the edge closing window a lands in S[3] after 3 more edges: visible in window a+4
    chk("stream_latency", first_ov - first_acc, 4);
    chk("stream_ready_low", rdy_low, 0);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    chk_seq("stream");

    // Backpressure and full pipe
    for (int c = 0; c < 4; c++) begin
      setin(1'b1, 8'(8'h10 + c), 1'b0);
      tick();
    end
    setin(1'b1, 8'h14, 1'b0);
    #3;
    chk("full_count", count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    tick();
    setin(1'b1, 8'h14, 1'b1);
    #3;
    chk("full_pass_in_ready", bus.in_ready, 1);
    chk("full_pass_out_data", bus.out_data, 8'h10);
    tick();
    setin(1'b0, 8'h00, 1'b0);
    #3;
    chk("full_after_count", count, 4);
    chk("full_after_out_data", bus.out_data, 8'h11);
    tick();
    drain(6);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14};
    chk_seq("bp_drain");

    // Bubble collapse
    setin(1'b1, 8'hA0, 1'b0); tick();
    setin(1'b0, 8'h00, 1'b0); tick(); tick();
    setin(1'b1, 8'hA1, 1'b0); tick();
    setin(1'b0, 8'h00, 1'b0); tick(); tick(); tick();
    #3;
    chk("bubble_count", count, 2);
    chk("bubble_out_data", bus.out_data, 8'hA0);
    tick();
    drain(5);
    exp_q = '{8'hA0, 8'hA1};
    chk_seq("bubble_drain");

    // Hold freezes everything
    setin(1'b1, 8'h21, 1'b0); tick();
    setin(1'b1, 8'h22, 1'b0); tick();
    setin(1'b0, 8'h00, 1'b0); tick(); tick(); tick();
    hold = 1'b1;
    setin(1'b1, 8'h99, 1'b1);
    repeat (3) begin
      #3;
      chk("hold_out_valid", bus.out_valid, 0);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_count", count, 2);
      tick();
    end
    hold = 1'b0;
    drain(5);
    exp_q = '{8'h21, 8'h22};
    chk_seq("hold_drain");
    #3;
    chk("hold_drained_count", count, 0);
    tick();

    // Flush with a held stream
    setin(1'b1, 8'h31, 1'b0); tick();
    setin(1'b1, 8'h32, 1'b0); tick();
    setin(1'b1, 8'h33, 1'b0); tick();
    setin(1'b0, 8'h00, 1'b0);
    #3;
    chk("pre_flush_count", count, 3);
    tick();
    flush = 1'b1;
    setin(1'b1, 8'h77, 1'b0);
    #3;
    chk("flush_in_ready", bus.in_ready, 0);
    chk("flush_out_valid", bus.out_valid, 0);
    tick();
    flush = 1'b0;
    setin(1'b0, 8'h00, 1'b1);
    #3;
    chk("post_flush_count", count, 0);
    chk("post_flush_out_valid", bus.out_valid, 0);
    tick();

    // Flush on an empty pipe drops the offered word
    flush = 1'b1;
    setin(1'b1, 8'h88, 1'b1);
    #3;
    chk("empty_flush_in_ready", bus.in_ready, 0);
    tick();
    flush = 1'b0;
    setin(1'b0, 8'h00, 1'b1);
    #3;
    chk("empty_flush_count", count, 0);
    tick();

    // Reset beats hold; data registers return to the reset value
    setin(1'b1, 8'h55, 1'b0); tick();
    rst  = 1'b1;
    hold = 1'b1;
    setin(1'b0, 8'h00, 1'b0);
    tick();
    #3;
    chk("rst_hold_count", count, 0);
    chk("rst_hold_out_data", bus.out_data, 8'h00);
    chk("rst_hold_in_ready", bus.in_ready, 0);
    chk("rst_hold_out_valid", bus.out_valid, 0);
    tick();
    rst  = 1'b0;
    hold = 1'b0;
    setin(1'b1, 8'h66, 1'b1);
    #3;
    chk("post_rst_in_ready", bus.in_ready, 1);
    tick();
    drain(6);
    exp_q = '{8'h66};
    chk_seq("post_rst_drain");

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
